// File: rtl/codificador_hamming_tx.sv
// Extended Hamming(8,4) SECDED encoder with optional single-bit error injection
// and a UART-style serialiser (start, 8 codeword bits LSB first, stop).
module codificador_hamming_tx #(
  parameter int unsigned DIV_BAUDIO = 4,
  parameter int unsigned ANCHO_DIV  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] conmutador_4,
  input  logic [3:0] pos_error_iny,
  input  logic       dato_valido,
  output logic       listo,
  output logic       tx,
  output logic [7:0] palabra_cod,
  output logic       fin_trama
);

  typedef enum logic [1:0] {REPOSO, INICIO, DATOS, PARADA} estado_t;

  // The final stop-bit cycle is spent in REPOSO (tx=1, listo=1, fin_trama=1),
  // so PARADA itself only covers the first DIV_BAUDIO-1 cycles of the stop bit.
  localparam int unsigned FIN_PARADA = (DIV_BAUDIO > 1) ? DIV_BAUDIO - 2 : 0;
  localparam logic [ANCHO_DIV-1:0] ULT_PER    = ANCHO_DIV'(DIV_BAUDIO - 1);
  localparam logic [ANCHO_DIV-1:0] ULT_PARADA = ANCHO_DIV'(FIN_PARADA);

  estado_t              estado;
  logic [ANCHO_DIV-1:0] cnt_per;
  logic [2:0]           cnt_bit;
  logic [7:0]           sr;
  logic [7:0]           cw_base;
  logic [7:0]           mascara;
  logic [7:0]           cw_in;
  logic                 fin_per;

  always_comb begin
    cw_base    = '0;
    cw_base[0] = conmutador_4[0] ^ conmutador_4[1] ^ conmutador_4[3];
    cw_base[1] = conmutador_4[0] ^ conmutador_4[2] ^ conmutador_4[3];
    cw_base[2] = conmutador_4[0];
    cw_base[3] = conmutador_4[1] ^ conmutador_4[2] ^ conmutador_4[3];
    cw_base[4] = conmutador_4[1];
    cw_base[5] = conmutador_4[2];
    cw_base[6] = conmutador_4[3];
    cw_base[7] = ^cw_base[6:0];
  end

  always_comb begin
    mascara = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pos_error_iny == 4'(i + 1)) mascara[i] = 1'b1;
    end
    cw_in = cw_base ^ mascara;
  end

  assign fin_per = (cnt_per == ULT_PER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= REPOSO;
      tx          <= 1'b1;
      palabra_cod <= '0;
      fin_trama   <= 1'b0;
      listo       <= 1'b1;
      cnt_per     <= '0;
      cnt_bit     <= '0;
      sr          <= '0;
    end else begin
      fin_trama <= 1'b0;
      case (estado)
        REPOSO: begin
          if (dato_valido && listo) begin
            sr          <= cw_in;
            palabra_cod <= cw_in;
            tx          <= 1'b0;
            cnt_per     <= '0;
            cnt_bit     <= '0;
            listo       <= 1'b0;
            estado      <= INICIO;
          end
        end
        INICIO: begin
          if (fin_per) begin
            cnt_per <= '0;
            cnt_bit <= '0;
            tx      <= sr[0];
            estado  <= DATOS;
          end else begin
            cnt_per <= cnt_per + 1'b1;
          end
        end
        DATOS: begin
          if (fin_per) begin
            cnt_per <= '0;
            if (cnt_bit == 3'd7) begin
              cnt_bit <= '0;
              tx      <= 1'b1;
              if (DIV_BAUDIO == 1) begin
                fin_trama <= 1'b1;
                listo     <= 1'b1;
                estado    <= REPOSO;
              end else begin
                estado <= PARADA;
              end
            end else begin
              cnt_bit <= cnt_bit + 3'd1;
              sr      <= {1'b0, sr[7:1]};
              tx      <= sr[1];
            end
          end else begin
            cnt_per <= cnt_per + 1'b1;
          end
        end
        PARADA: begin
          if (cnt_per == ULT_PARADA) begin
            cnt_per   <= '0;
            fin_trama <= 1'b1;
            listo     <= 1'b1;
            estado    <= REPOSO;
          end else begin
            cnt_per <= cnt_per + 1'b1;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_codificador_hamming_tx.sv
// Scoreboard bench: driver pushes model codewords, monitor decodes the serial
// line and checks frame timing, captured byte and palabra_cod.
module tb_codificador_hamming_tx;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] conmutador_4 = '0;
  logic [3:0] pos_error_iny = '0;
  logic       dato_valido = 1'b0;
  logic       listo;
  logic       tx;
  logic [7:0] palabra_cod;
  logic       fin_trama;

  int checks = 0;
  int failures = 0;
  int ciclo = 0;

  logic [7:0] esperado_q[$];

  bit         en_trama = 1'b0;
  int         off = 0;
  logic [7:0] capt = '0;
  int         fin_ultimo = -1;
  int         fin_previo = -1;
  int         tramas_ok = 0;

  codificador_hamming_tx #(.DIV_BAUDIO(DIV), .ANCHO_DIV(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .conmutador_4  (conmutador_4),
    .pos_error_iny (pos_error_iny),
    .dato_valido   (dato_valido),
    .listo         (listo),
    .tx            (tx),
    .palabra_cod   (palabra_cod),
    .fin_trama     (fin_trama)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ciclo++;

  // Reference: classic Hamming positions 1..7, parity at powers of two,
  // overall parity in bit 7, then optional flip.
  function automatic logic [7:0] modelo(input logic [3:0] d, input logic [3:0] pos);
    logic [7:0] w;
    int k;
    logic par;
    w = '0;
    k = 0;
    for (int j = 1; j <= 7; j++) begin
      if ((j & (j - 1)) != 0) begin
        w[j-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int j = 1; j <= 7; j++)
        if (((j & p) != 0) && (j != p)) par = par ^ w[j-1];
      w[p-1] = par;
    end
    w[7] = ($countones(w[6:0]) % 2) == 1;
    if (pos >= 4'd1 && pos <= 4'd8) w[int'(pos) - 1] = ~w[int'(pos) - 1];
    return w;
  endfunction

  task automatic comparar(input string nombre, input logic [31:0] actual, input logic [31:0] req);
    checks++;
    if (actual !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nombre, actual, req);
    end
  endtask

  task automatic esperar_listo();
    int n;
    n = 0;
    @(negedge clk);
    while (!listo && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!listo) begin
      checks++;
      failures++;
      $display("FAIL timeout_listo: actual=0 required=1");
    end
  endtask

  task automatic enviar(input logic [3:0] nib, input logic [3:0] pos, input bit mantener);
    esperar_listo();
    conmutador_4  = nib;
    pos_error_iny = pos;
    dato_valido   = 1'b1;
    @(posedge clk);
    esperado_q.push_back(modelo(nib, pos));
    if (!mantener) begin
      #1;
      dato_valido = 1'b0;
    end
  endtask

  task automatic dirigido(input string nombre, input logic [3:0] nib, input logic [3:0] pos,
                          input logic [7:0] req);
    enviar(nib, pos, 1'b0);
    esperar_listo();
    comparar(nombre, palabra_cod, req);
  endtask

  // Monitor: samples mid-bit on the falling edge, checks fin_trama lands on the
  // last cycle of the 10*DIV frame and compares against the scoreboard.
  initial begin
    logic [7:0] exp_cw;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_trama = 1'b0;
      end else begin
        if (!en_trama) begin
          if (fin_trama) comparar("fin_fuera_de_trama", fin_trama, 0);
          if (tx == 1'b0) begin
            en_trama = 1'b1;
            off = 0;
            capt = '0;
          end
        end
        if (en_trama) begin
          if ((off % DIV) == (DIV / 2)) begin
            if (off / DIV == 0) comparar("bit_inicio", tx, 0);
            else if (off / DIV <= 8) capt[off / DIV - 1] = tx;
            else comparar("bit_parada", tx, 1);
          end
          if (off == 10 * DIV - 1) begin
            comparar("fin_trama_final", fin_trama, 1);
            if (esperado_q.size() == 0) begin
              comparar("cola_vacia_en_trama", 0, 1);
            end else begin
              exp_cw = esperado_q.pop_front();
              comparar("serie", capt, exp_cw);
              comparar("palabra_cod", palabra_cod, exp_cw);
            end
            fin_previo = fin_ultimo;
            fin_ultimo = ciclo;
            tramas_ok++;
            en_trama = 1'b0;
          end else if (fin_trama) begin
            comparar("fin_prematuro", fin_trama, 0);
          end
          off++;
        end
      end
    end
  end

  initial begin
    logic [7:0] obs[16];
    int dmin;
    int n;
    bit limpio;
    logic [3:0] nib_a;

    repeat (3) @(negedge clk);
    comparar("reset_tx", tx, 1);
    comparar("reset_listo", listo, 1);
    comparar("reset_palabra", palabra_cod, 8'h00);
    comparar("reset_fin", fin_trama, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    dirigido("cw_1011", 4'b1011, 4'd0, 8'h55);
    dirigido("iny_3", 4'b1011, 4'd3, 8'h51);
    dirigido("iny_8", 4'b1011, 4'd8, 8'hD5);
    dirigido("iny_12", 4'b1011, 4'd12, 8'h55);

    // Back-to-back: second transfer happens in the fin_trama/listo cycle.
    enviar(4'b1111, 4'd0, 1'b1);
    enviar(4'b0000, 4'd0, 1'b0);
    esperar_listo();
    comparar("b2b_palabra", palabra_cod, 8'h00);
    comparar("b2b_separacion", fin_ultimo - fin_previo, 10 * DIV);

    // Exhaustive nibbles: distance/weight properties of the received words.
    for (int i = 0; i < 16; i++) begin
      enviar(4'(i), 4'd0, 1'b0);
      esperar_listo();
      obs[i] = palabra_cod;
    end
    dmin = 8;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (($countones(obs[i]) % 2) != 0) n++;
      for (int j = i + 1; j < 16; j++)
        if ($countones(obs[i] ^ obs[j]) < dmin) dmin = $countones(obs[i] ^ obs[j]);
    end
    comparar("peso_impar_cnt", n, 0);
    comparar("distancia_min", dmin, 4);

    // dato_valido during DATOS must be ignored.
    nib_a = 4'b0110;
    enviar(nib_a, 4'd0, 1'b0);
    repeat (3 * DIV + 2) @(negedge clk);
    comparar("listo_en_datos", listo, 0);
    conmutador_4 = 4'b1001;
    pos_error_iny = 4'd5;
    dato_valido = 1'b1;
    @(negedge clk);
    dato_valido = 1'b0;
    comparar("ignorado_palabra", palabra_cod, modelo(nib_a, 4'd0));
    esperar_listo();

    // Randomized traffic, sometimes back-to-back.
    for (int i = 0; i < 30; i++)
      enviar(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
    dato_valido = 1'b0;
    esperar_listo();

    // Reset mid-frame aborts the frame asynchronously.
    enviar(4'b1011, 4'd0, 1'b0);
    repeat (3 * DIV + 1) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    comparar("rst_async_tx", tx, 1);
    comparar("rst_async_listo", listo, 1);
    esperado_q.delete();
    n = tramas_ok;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    limpio = 1'b1;
    for (int i = 0; i < 15 * DIV; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fin_trama !== 1'b0) limpio = 1'b0;
    end
    comparar("post_reset_inactivo", limpio, 1);
    comparar("post_reset_sin_trama", tramas_ok, n);

    n = 0;
    while (esperado_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    comparar("cola_drenada", esperado_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
